user_stream_fifo: RTL
=====================

# user_stream_fifo

Elastic buffer between one HLS kernel output port (`Output_k_V_V` / `_ap_vld` / `_ap_ack`) and the matching `din_leaf_user2interface` / `vld_user2interface` / `ack_interface2user` lane of `leaf_interface`. It absorbs BFT back-pressure so the kernel does not stall on every packet-level hiccup. It reports occupancy for freespace accounting and debug. One instance per output port, instantiated in each leaf `top`.

## Interface
Parameters:
- `PAYLOAD_BITS`, 32, word width; matches the `leaf_interface` payload width.
- `DEPTH_BITS`, 7, log2 of storage depth; capacity is 2^DEPTH_BITS words, matching `NUM_BRAM_ADDR_BITS`.
- `ALMOST_FULL_GAP`, 4, `almost_full` asserts when free space is at or below this value.

Ports:
- `clk`, input, 1, the single clock; all logic is on the rising edge.
- `reset`, input, 1, synchronous, active-high.
- `din`, input, PAYLOAD_BITS, word from the kernel.
- `din_vld`, input, 1, kernel word valid.
- `din_ack`, output, 1, FIFO accepts the word this cycle.
- `dout`, output, PAYLOAD_BITS, word to `leaf_interface`.
- `dout_vld`, output, 1, `dout` holds a valid word.
- `dout_ack`, input, 1, `leaf_interface` takes the word this cycle.
- `count`, output, DEPTH_BITS+1, words held, including the output register.
- `almost_full`, output, 1, asserts when `count >= 2^DEPTH_BITS - ALMOST_FULL_GAP`.
- `empty`, output, 1, asserts when `count == 0`.

## Operation
- A transfer occurs in a cycle where vld and ack are both high on the same side. Nothing else constitutes a transfer.
- `din_ack = !full`, where `full = (count == 2^DEPTH_BITS)`. It is a combinational function of registered state only and does not depend on `din_vld`.
- `dout_vld` never drops and `dout` never changes while `dout_vld=1` and `dout_ack=0`.
- Storage consists of:
  - a RAM array with registered read;
  - a one-entry prefetch stage;
  - the output register.
- Data path is first-word-fall-through: the output register refills from RAM without waiting for a request.
- Prefetch FSM states:
  - `EMPTY`: output register invalid.
  - `LOADING`: RAM read issued, result not yet in the output register.
  - `VALID`: output register holds the head word.
- FSM transitions:
  - `EMPTY` → `LOADING` when the RAM is non-empty.
  - `LOADING` → `VALID` one cycle later.
  - `VALID` → `LOADING` on an output transfer while the RAM is non-empty.
  - `VALID` → `EMPTY` on an output transfer while the RAM is empty.
- Read and write pointers are DEPTH_BITS wide and wrap modulo 2^DEPTH_BITS.
- `count` changes per cycle as follows:
  - +1 on an input-only transfer;
  - −1 on an output-only transfer;
  - unchanged when input and output transfers happen in the same cycle.
- Simultaneous transfers:
  - At full, `din_ack=0`, so no write occurs even if a read happens in that cycle. The freed slot is offered on the next cycle.
  - On an empty RAM with the output register draining, a new write is not bypassed; it follows the normal latency.
- Reset clears pointers, `count`, and FSM (to `EMPTY`). RAM contents are not cleared.
- Reset mid-stream discards all buffered words. No partial word is emitted after reset.

## Timing
- Reset values: `dout_vld=0`, `dout=0`, `din_ack=1`, `count=0`, `empty=1`, `almost_full=0`.
- Latency: a word accepted on an empty FIFO in cycle N has `dout_vld=1` in cycle N+2.
- Sustained throughput is 1 word/cycle in both directions, with no bubbles once the output register is valid and `dout_ack` stays high.
- `count`, `empty`, and `almost_full` are registered and reflect transfers from the previous cycle.
- `din_ack` deasserts in the cycle after the transfer that fills the FIFO.

## Structure
- Shared package `bft_user_pkg`: `PAYLOAD_BITS` default and the handshake transfer-qualifier function; the same function serves the input and output handshakes.
- One sub-module, `user_fifo_ram`: a simple dual-port RAM (one write port, one registered read port, DEPTH_BITS address width) that infers BRAM.
- The prefetch FSM, pointers, and counters live in `user_stream_fifo`.

## Test plan
- Single word: after reset, present `din=0xDEADBEEF` with `din_vld=1` for 1 cycle (N), `dout_ack=0`. Required: `dout_vld=1` and `dout=0xDEADBEEF` from cycle N+2; `count=1`; value held until `dout_ack`.
- Fill: `dout_ack=0`, write 128 words 0..127. Required:
  - `almost_full` rises when `count=124`;
  - `din_ack=0` once `count=128`;
  - a 129th `din_vld` is not accepted.
- Drain at full with simultaneous write attempt: with `count=128`, hold `dout_ack=1` and `din_vld=1`. Required:
  - the first cycle reads word 0 and writes nothing;
  - then steady 1-in/1-out with `count` at 127/128;
  - output order is exactly 0,1,2,….
- Wrap-around: stream 300 words with random `din_vld` and `dout_ack` (50% each). Required: output sequence equals input sequence and `count` never exceeds 128.
- Back-to-back throughput: `dout_ack=1` constant and `din_vld=1` for 64 cycles. Required: after 2-cycle fill latency, `dout_vld=1` every cycle for 64 consecutive cycles.
- Reset mid-operation: with `count=50`, assert `reset` for 1 cycle. Required: the next cycle shows `dout_vld=0`, `count=0`, `din_ack=1`. The next word written (0x12345678) is the first output, after 2 cycles.

Source files
------------

// File: rtl/bft_user_pkg.sv
// rtl/bft_user_pkg.sv - shared payload width, prefetch states and handshake qualifier
package bft_user_pkg;

  localparam int BFT_PAYLOAD_BITS = 32;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_VALID   = 2'd2
  } pf_state_e;

  // A word moves only when both sides of one handshake agree in the same cycle.
  function automatic logic hs_xfer(input logic vld, input logic ack);
    return vld & ack;
  endfunction

endpackage

// File: rtl/user_fifo_ram.sv
// rtl/user_fifo_ram.sv - simple dual-port RAM, one write port and one registered read port
module user_fifo_ram
  import bft_user_pkg::*;
#(
  parameter int WIDTH     = BFT_PAYLOAD_BITS,
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<ADDR_BITS)-1];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Write-first on a same-address collision: only happens when the RAM is empty
  // and the word being written is also the next one to prefetch.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_q <= wr_data_i;
      end else begin
        rd_data_q <= mem_q[rd_addr_i];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/user_stream_fifo.sv
// rtl/user_stream_fifo.sv - first-word-fall-through elastic buffer between a kernel output port and leaf_interface
module user_stream_fifo
  import bft_user_pkg::*;
#(
  parameter int PAYLOAD_BITS    = BFT_PAYLOAD_BITS,
  parameter int DEPTH_BITS      = 7,
  parameter int ALMOST_FULL_GAP = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    din_vld,
  output logic                    din_ack,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_ack,
  output logic [DEPTH_BITS:0]     count,
  output logic                    almost_full,
  output logic                    empty
);

  localparam logic [DEPTH_BITS:0]   FULL_CNT = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   AF_CNT   = FULL_CNT - ALMOST_FULL_GAP[DEPTH_BITS:0];
  localparam logic [DEPTH_BITS:0]   CNT_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

  pf_state_e               state_q;
  logic [PAYLOAD_BITS-1:0] dout_q;
  logic                    pf_vld_q, pf_vld_d;
  logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]     count_q, count_d;
  logic                    almost_full_q, empty_q;

  logic [PAYLOAD_BITS-1:0] ram_rd_data;
  logic [DEPTH_BITS:0]     ram_words;
  logic                    out_vld;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    ram_avail;
  logic                    out_load;
  logic                    rd_en;

  assign out_vld  = (state_q == ST_VALID);
  assign din_ack  = (count_q != FULL_CNT);
  assign in_xfer  = hs_xfer(din_vld, din_ack);
  assign out_xfer = hs_xfer(out_vld, dout_ack);

  // count covers RAM, prefetch and output register; the RAM holds the remainder.
  assign ram_words = count_q
                   - {{DEPTH_BITS{1'b0}}, pf_vld_q}
                   - {{DEPTH_BITS{1'b0}}, out_vld};
  assign ram_avail = (ram_words != '0) || in_xfer;
  assign out_load  = pf_vld_q && (!out_vld || out_xfer);
  assign rd_en     = ram_avail && (!pf_vld_q || out_load);

  user_fifo_ram #(
    .WIDTH     (PAYLOAD_BITS),
    .ADDR_BITS (DEPTH_BITS)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (in_xfer),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (din),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pf_vld_d = pf_vld_q;
    count_d  = count_q;
    if (in_xfer) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      pf_vld_d = 1'b1;
    end else if (out_load) begin
      pf_vld_d = 1'b0;
    end
    case ({in_xfer, out_xfer})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pf_vld_q      <= 1'b0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      empty_q       <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pf_vld_q      <= pf_vld_d;
      count_q       <= count_d;
      almost_full_q <= (count_d >= AF_CNT);
      empty_q       <= (count_d == '0);
    end
  end

  // Output-register FSM; a valid prefetch lets VALID hold across transfers with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      dout_q  <= '0;
    end else begin
      if (out_load) begin
        dout_q <= ram_rd_data;
      end
      case (state_q)
        ST_EMPTY: begin
          if (rd_en) begin
            state_q <= ST_LOADING;
          end
        end
        ST_LOADING: begin
          state_q <= ST_VALID;
        end
        ST_VALID: begin
          if (out_xfer && !pf_vld_q) begin
            state_q <= rd_en ? ST_LOADING : ST_EMPTY;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  assign dout        = dout_q;
  assign dout_vld    = out_vld;
  assign count       = count_q;
  assign almost_full = almost_full_q;
  assign empty       = empty_q;

endmodule
